// File: rtl/sipo_frame_ctrl.sv
// Frame-oriented serial-in/parallel-out capture controller: shifts qualified serial
// bits into words, hands each word to a consumer through a valid/ready holding register.
module sipo_frame_ctrl #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned FRAME_WORDS = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic                                 s_in,
  input  logic                                 s_valid,
  output logic [WIDTH-1:0]                     p_out,
  output logic                                 p_valid,
  input  logic                                 p_ready,
  output logic                                 p_last,
  output logic                                 busy,
  output logic                                 overrun,
  output logic [$clog2(FRAME_WORDS+1)-1:0]     word_cnt
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(FRAME_WORDS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_WORDS);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [BW-1:0]     bit_cnt;
  logic [WIDTH-1:0]  shift_reg;

  logic              start_frame;
  logic              abort_frame;
  logic              shift_en;
  logic              word_done;
  logic              accept;
  logic              drop;
  logic              frame_done;
  logic [CW-1:0]     word_cnt_inc;
  logic [WIDTH-1:0]  shifted;

  // Abort takes priority over a bit arriving in the same cycle.
  assign start_frame  = (state == IDLE) && start;
  assign abort_frame  = (state == SHIFT) && abort;
  assign shift_en     = (state == SHIFT) && s_valid && !abort;
  assign word_done    = shift_en && (bit_cnt == LAST_BIT);
  assign accept       = p_valid && p_ready;
  assign drop         = word_done && p_valid && !p_ready;
  assign word_cnt_inc = CW'(word_cnt + 1'b1);
  assign frame_done   = word_done && (word_cnt_inc == LAST_CNT);
  assign shifted      = {s_in, shift_reg[WIDTH-1:1]};
  assign busy         = (state == SHIFT);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (abort || frame_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register, bit/word counters and sticky overrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      word_cnt  <= '0;
      overrun   <= 1'b0;
    end else if (start_frame) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      word_cnt  <= '0;
      overrun   <= 1'b0;
    end else if (abort_frame) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= shifted;
      if (word_done) begin
        bit_cnt  <= '0;
        word_cnt <= word_cnt_inc;
      end else begin
        bit_cnt <= BW'(bit_cnt + 1'b1);
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

  // Output holding register; a completed word that cannot be stored is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_out   <= '0;
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end else if (word_done && !drop) begin
      p_out   <= shifted;
      p_valid <= 1'b1;
      p_last  <= (word_cnt_inc == LAST_CNT);
    end else if (accept) begin
      p_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Scoreboard bench for sipo_frame_ctrl (WIDTH=4, FRAME_WORDS=2): stimulus pushes expected
// words, a monitor pops and compares on every accepted output word.
module tb_sipo_frame_ctrl;

  localparam int unsigned WIDTH       = 4;
  localparam int unsigned FRAME_WORDS = 2;
  localparam int unsigned CW          = $clog2(FRAME_WORDS + 1);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             s_in = 1'b0;
  logic             s_valid = 1'b0;
  logic             p_ready = 1'b0;
  logic [WIDTH-1:0] p_out;
  logic             p_valid;
  logic             p_last;
  logic             busy;
  logic             overrun;
  logic [CW-1:0]    word_cnt;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  sipo_frame_ctrl #(.WIDTH(WIDTH), .FRAME_WORDS(FRAME_WORDS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .s_in     (s_in),
    .s_valid  (s_valid),
    .p_out    (p_out),
    .p_valid  (p_valid),
    .p_ready  (p_ready),
    .p_last   (p_last),
    .busy     (busy),
    .overrun  (overrun),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    s_in    = b;
    s_valid = 1'b1;
    cyc();
    s_valid = 1'b0;
    s_in    = 1'b0;
  endtask

  task automatic send4(input logic b0, input logic b1, input logic b2, input logic b3);
    send_bit(b0);
    send_bit(b1);
    send_bit(b2);
    send_bit(b3);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    q.push_back(e);
  endtask

  // Compare every word the consumer actually takes against the scoreboard.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && p_valid && p_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got p_out=%0h p_last=%0b, no word expected at %0t",
                   p_out, p_last, $time);
        end else begin
          e = q.pop_front();
          chk("sb_p_out", int'(p_out), int'(e.data));
          chk("sb_p_last", int'(p_last), int'(e.last));
        end
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_p_out"}, int'(p_out), 0);
    chk({tag, "_p_valid"}, int'(p_valid), 0);
    chk({tag, "_p_last"}, int'(p_last), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
    chk({tag, "_word_cnt"}, int'(word_cnt), 0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    gap(2);
    chk_all_zero("reset");
    reset = 1'b1;
    cyc();

    // Basic capture and full frame, p_ready held high
    p_ready = 1'b1;
    pulse_start();
    chk("start_busy", int'(busy), 1);
    chk("start_word_cnt", int'(word_cnt), 0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    push(4'hD, 1'b0);
    send_bit(1'b1);
    chk("w1_p_valid", int'(p_valid), 1);
    chk("w1_p_out", int'(p_out), 'hD);
    chk("w1_p_last", int'(p_last), 0);
    chk("w1_word_cnt", int'(word_cnt), 1);
    chk("w1_busy", int'(busy), 1);
    send_bit(1'b0);
    chk("w1_one_cycle", int'(p_valid), 0);
    send_bit(1'b0);
    send_bit(1'b0);
    push(4'h8, 1'b1);
    send_bit(1'b1);
    chk("w2_p_out", int'(p_out), 'h8);
    chk("w2_p_last", int'(p_last), 1);
    chk("w2_busy", int'(busy), 0);
    chk("w2_word_cnt", int'(word_cnt), 2);

    // Back-to-back start, then backpressure for the whole frame
    pulse_start();
    p_ready = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_word_cnt", int'(word_cnt), 0);
    chk("b2b_p_valid", int'(p_valid), 0);
    push(4'hD, 1'b0);
    send4(1'b1, 1'b0, 1'b1, 1'b1);
    send4(1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_overrun", int'(overrun), 1);
    chk("bp_busy", int'(busy), 0);
    chk("bp_p_out", int'(p_out), 'hD);
    chk("bp_p_last", int'(p_last), 0);
    chk("bp_word_cnt", int'(word_cnt), 2);
    gap(2);
    chk("bp_p_valid_held", int'(p_valid), 1);
    p_ready = 1'b1;
    cyc();
    p_ready = 1'b0;
    chk("bp_drained", int'(p_valid), 0);
    pulse_start();
    chk("bp_overrun_clr", int'(overrun), 0);

    // Gapped bits; accept coincides with completion of word 2
    push(4'hD, 1'b0);
    send_bit(1'b1);
    gap(2);
    send_bit(1'b0);
    send_bit(1'b1);
    gap(int'($urandom_range(1, 3)));
    send_bit(1'b1);
    gap(1);
    push(4'h8, 1'b1);
    send_bit(1'b0);
    gap(3);
    send_bit(1'b0);
    send_bit(1'b0);
    gap(int'($urandom_range(1, 2)));
    p_ready = 1'b1;
    send_bit(1'b1);
    p_ready = 1'b0;
    chk("gap_overrun", int'(overrun), 0);
    chk("gap_p_valid", int'(p_valid), 1);
    chk("gap_p_out", int'(p_out), 'h8);
    chk("gap_p_last", int'(p_last), 1);
    gap(1);
    p_ready = 1'b1;
    cyc();
    chk("gap_drained", int'(p_valid), 0);

    // Abort mid-word, then a clean word; s_valid on the start cycle is ignored
    pulse_start();
    send_bit(1'b1);
    send_bit(1'b1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    cyc();
    chk("abort_p_valid", int'(p_valid), 0);
    start   = 1'b1;
    s_valid = 1'b1;
    s_in    = 1'b1;
    cyc();
    start   = 1'b0;
    s_valid = 1'b0;
    s_in    = 1'b0;
    push(4'hE, 1'b0);
    send4(1'b0, 1'b1, 1'b1, 1'b1);
    chk("abort_p_out", int'(p_out), 'hE);
    chk("abort_word_cnt", int'(word_cnt), 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort2_busy", int'(busy), 0);

    // Asynchronous reset while a word is held
    p_ready = 1'b0;
    pulse_start();
    send4(1'b1, 1'b0, 1'b1, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("pre_reset_p_valid", int'(p_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    cyc();
    reset = 1'b1;
    p_ready = 1'b1;
    pulse_start();
    push(4'hD, 1'b0);
    send4(1'b1, 1'b0, 1'b1, 1'b1);
    chk("post_reset_p_out", int'(p_out), 'hD);
    chk("post_reset_word_cnt", int'(word_cnt), 1);
    gap(3);

    chk("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
